// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nor2_bist.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__nor2_bist.sv - self-test driver/checker for NOR2 cells
// Applies the Gray sequence 00,10,11,01 on the shared {A1,A2} inputs for PASSES
// sweeps, samples every ZN after SETTLE idle cycles and accumulates mismatches.
module gf180mcu_fd_sc_mcu9t5v0__nor2_bist #(
  parameter int N_CELLS = 4,
  parameter int PASSES  = 2,
  parameter int SETTLE  = 1,
  parameter int ERR_W   = 8
) (
`ifdef USE_POWER_PINS
  inout  wire                VDD,
  inout  wire                VSS,
`endif
  input  logic               CLK,
  input  logic               RN,
  input  logic               START,
  input  logic [N_CELLS-1:0] ZN,
  output logic               A1,
  output logic               A2,
  output logic               BUSY,
  output logic               DONE,
  output logic               PASS,
  output logic [ERR_W-1:0]   ERR_CNT,
  output logic [N_CELLS-1:0] FAIL_MAP
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [PW-1:0] PASS_LAST   = PW'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE_W, SAMPLE, FIN} state_e;

  // With no settle time the checker samples on the edge right after driving.
  localparam state_e FIRST_WAIT = (SETTLE == 0) ? SAMPLE : SETTLE_W;

  state_e             state_q, state_d;
  logic               a1_q, a1_d;
  logic               a2_q, a2_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [N_CELLS-1:0] fail_map_q, fail_map_d;
  logic [1:0]         vec_q, vec_d;
  logic [PW-1:0]      pass_q, pass_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [N_CELLS-1:0] mism;
  logic [1:0]         nxt_vec;
  logic [1:0]         drive;

  // Vector index to {A1,A2}: 0->00, 1->10, 2->11, 3->01 (one input toggles per step).
  function automatic logic [1:0] vec_drive(input logic [1:0] idx);
    return {idx[1] ^ idx[0], idx[1]};
  endfunction

  // State and result registers; reset discards any partial run.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= IDLE;
      a1_q       <= 1'b0;
      a2_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
      fail_map_q <= '0;
      vec_q      <= '0;
      pass_q     <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
      fail_map_q <= fail_map_d;
      vec_q      <= vec_d;
      pass_q     <= pass_d;
      settle_q   <= settle_d;
    end
  end

  // Next-state: start/restart, settle countdown, sample-and-advance.
  always_comb begin
    state_d    = state_q;
    a1_d       = a1_q;
    a2_d       = a2_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_cnt_d  = err_cnt_q;
    fail_map_d = fail_map_q;
    vec_d      = vec_q;
    pass_d     = pass_q;
    settle_d   = settle_q;
    mism       = ZN ^ {N_CELLS{~(a1_q | a2_q)}};
    nxt_vec    = vec_q + 2'd1;
    drive      = vec_drive(nxt_vec);

    case (state_q)
      IDLE, FIN: begin
        if (START) begin
          err_cnt_d  = '0;
          fail_map_d = '0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          vec_d      = '0;
          pass_d     = '0;
          settle_d   = '0;
          a1_d       = 1'b0;
          a2_d       = 1'b0;
          state_d    = FIRST_WAIT;
        end
      end
      SETTLE_W: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      SAMPLE: begin
        fail_map_d = fail_map_q | mism;
        if ((|mism) && !(&err_cnt_q)) begin
          err_cnt_d = err_cnt_q + ERR_W'(1);
        end
        if (vec_q == 2'd3 && pass_q == PASS_LAST) begin
          a1_d    = 1'b0;
          a2_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          vec_d    = nxt_vec;
          a1_d     = drive[1];
          a2_d     = drive[0];
          settle_d = '0;
          if (vec_q == 2'd3) begin
            pass_d = pass_q + PW'(1);
          end
          state_d = FIRST_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign A1       = a1_q;
  assign A2       = a2_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = done_q & (err_cnt_q == '0);
  assign ERR_CNT  = err_cnt_q;
  assign FAIL_MAP = fail_map_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__nor2_bist.sv
// tb/tb_gf180mcu_fd_sc_mcu9t5v0__nor2_bist.sv - randomized self-checking bench for the NOR2 BIST
module tb_gf180mcu_fd_sc_mcu9t5v0__nor2_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rn;
  logic            start_a, start_b;
  logic [3:0]      st1, st0;
  logic [3:0][3:0] flip;
  logic [3:0]      za, zb;

  logic       a_a1, a_a2, a_busy, a_done, a_pass;
  logic [7:0] a_err;
  logic [3:0] a_map;
  logic       b_a1, b_a2, b_busy, b_done, b_pass;
  logic [1:0] b_err;
  logic [3:0] b_map;

  int n_cmp = 0;
  int n_bad = 0;
  int sel   = 0;
  logic [1:0] seq [4];

  // DUT A: defaults. DUT B: long run, tiny saturating counter, zero settle.
  gf180mcu_fd_sc_mcu9t5v0__nor2_bist dut_a (
    .CLK(clk), .RN(rn), .START(start_a), .ZN(za),
    .A1(a_a1), .A2(a_a2), .BUSY(a_busy), .DONE(a_done), .PASS(a_pass),
    .ERR_CNT(a_err), .FAIL_MAP(a_map)
  );

  gf180mcu_fd_sc_mcu9t5v0__nor2_bist #(.N_CELLS(4), .PASSES(8), .SETTLE(0), .ERR_W(2)) dut_b (
    .CLK(clk), .RN(rn), .START(start_b), .ZN(zb),
    .A1(b_a1), .A2(b_a2), .BUSY(b_busy), .DONE(b_done), .PASS(b_pass),
    .ERR_CNT(b_err), .FAIL_MAP(b_map)
  );

  // Faulty NOR cell models: ideal NOR, per-input-pattern flips, then stuck-at overrides.
  always_comb begin
    za = {4{~(a_a1 | a_a2)}} ^ flip[{a_a1, a_a2}];
    za = (za | st1) & ~st0;
  end

  always_comb begin
    zb = {4{~(b_a1 | b_a2)}} ^ flip[{b_a1, b_a2}];
    zb = (zb | st1) & ~st0;
  end

  logic [1:0]  o_vec;
  logic        o_busy, o_done, o_pass;
  logic [31:0] o_err;
  logic [3:0]  o_map;

  always_comb begin
    o_vec  = sel != 0 ? {b_a1, b_a2} : {a_a1, a_a2};
    o_busy = sel != 0 ? b_busy : a_busy;
    o_done = sel != 0 ? b_done : a_done;
    o_pass = sel != 0 ? b_pass : a_pass;
    o_err  = sel != 0 ? 32'(b_err) : 32'(a_err);
    o_map  = sel != 0 ? b_map : a_map;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic rand_faults();
    st1 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
    st0 = ($urandom_range(0, 2) == 0) ? (4'($urandom) & ~st1) : 4'h0;
    for (int v = 0; v < 4; v++) begin
      flip[v] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    end
  endtask

  // Expected results from the fault tables: one count per faulty vector, saturated.
  task automatic model(input int passes, input int errw, output int e_err, output logic [3:0] e_map);
    int cnt = 0;
    logic [3:0] ideal, act, m;
    logic [1:0] pr;
    e_map = 4'h0;
    for (int p = 0; p < passes; p++) begin
      for (int v = 0; v < 4; v++) begin
        pr    = seq[v];
        ideal = (pr == 2'b00) ? 4'hF : 4'h0;
        act   = ((ideal ^ flip[pr]) | st1) & ~st0;
        m     = act ^ ideal;
        if (m != 4'h0) cnt++;
        e_map |= m;
      end
    end
    e_err = (cnt > (1 << errw) - 1) ? (1 << errw) - 1 : cnt;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_a"}, 32'({a_a1, a_a2, a_busy, a_done, a_pass, a_err, a_map}), 32'h0);
    check({tag, "_b"}, 32'({b_a1, b_a2, b_busy, b_done, b_pass, b_err, b_map}), 32'h0);
  endtask

  // One or more back-to-back runs; with hold, START stays high so each completion restarts.
  task automatic run(input int which, input int nruns, input bit hold,
                     input logic [3:0] s1, input logic [3:0] s0, input logic [15:0] fl,
                     input bit rnd);
    int passes, settle, errw, len, e_err;
    logic [3:0] e_map;
    sel    = which;
    passes = (which != 0) ? 8 : 2;
    settle = (which != 0) ? 0 : 1;
    errw   = (which != 0) ? 2 : 8;
    len    = passes * 4 * (settle + 1);
    if (rnd) rand_faults();
    else begin
      st1  = s1;
      st0  = s0;
      flip = fl;
    end
    model(passes, errw, e_err, e_map);
    if (which != 0) start_b = 1'b1;
    else start_a = 1'b1;
    @(negedge clk);
    for (int r = 0; r < nruns; r++) begin
      if (!(hold && r < nruns - 1)) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      check("clr_err", o_err, 32'd0);
      check("clr_map", 32'(o_map), 32'd0);
      for (int t = 0; t < len; t++) begin
        check("vec", 32'(o_vec), 32'(seq[(t / (settle + 1)) % 4]));
        check("busy", 32'(o_busy), 32'd1);
        check("done_early", 32'(o_done), 32'd0);
        @(negedge clk);
      end
      check("vec_end", 32'(o_vec), 32'd0);
      check("busy_end", 32'(o_busy), 32'd0);
      check("done", 32'(o_done), 32'd1);
      check("pass", 32'(o_pass), 32'(e_err == 0));
      check("err_cnt", o_err, 32'(e_err));
      check("fail_map", 32'(o_map), 32'(e_map));
      if (r < nruns - 1) begin
        if (rnd) rand_faults();
        model(passes, errw, e_err, e_map);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
    st1 = 4'h0; st0 = 4'h0; flip = '0;
    rn = 1'b0; start_a = 1'b0; start_b = 1'b0;

    // Reset held with random START and ZN activity.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_zero("reset");
      start_a = 1'($urandom);
      start_b = 1'($urandom);
      rand_faults();
    end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    rn = 1'b1;
    @(negedge clk);

    run(0, 1, 1'b0, 4'h0, 4'h0, 16'h0, 1'b0);      // ideal cells
    run(0, 1, 1'b0, 4'b0100, 4'h0, 16'h0, 1'b0);   // ZN[2] stuck at 1 -> 6 errors
    run(1, 1, 1'b0, 4'h0, 4'hF, 16'h0, 1'b0);      // all stuck at 0 -> saturate at 3

    // Abort mid-run with reset, then a clean full run.
    sel = 0;
    st1 = 4'h0; st0 = 4'h0; flip = '0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy", 32'(a_busy), 32'd1);
    rn = 1'b0;
    #1;
    chk_zero("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_zero("abort_hold");
      start_a = 1'($urandom);
      start_b = 1'($urandom);
    end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    rn = 1'b1;
    @(negedge clk);
    run(0, 1, 1'b0, 4'h0, 4'h0, 16'h0, 1'b0);

    // START held through runs: no mid-run restart, restart on each completion.
    run(0, 3, 1'b1, 4'h0, 4'h0, 16'h0, 1'b1);
    run(1, 2, 1'b1, 4'h0, 4'h0, 16'h0, 1'b1);

    // Randomized runs on both configurations.
    for (int i = 0; i < 12; i++) begin
      int w, n;
      w = $urandom_range(0, 1);
      n = $urandom_range(1, 2);
      run(w, n, n > 1, 4'h0, 4'h0, 16'h0, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
